// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - RV32I load/store funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - responder state type and state constants (IDLE / WAIT / RESP)
//   - legal range of the LATENCY parameter and a clamp helper
//   - funct3 legality helper shared by the lane controller
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;

  // Out-of-range latencies are pulled back into the range the 4-bit counter supports.
  function automatic int clamp_latency(input int lat);
    int v;
    if (lat < LATENCY_MIN) begin
      v = LATENCY_MIN;
    end else if (lat > LATENCY_MAX) begin
      v = LATENCY_MAX;
    end else begin
      v = lat;
    end
    return v;
  endfunction

  // Stores only have byte/half/word; loads additionally have the unsigned variants.
  function automatic logic f3_is_legal(input logic write, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (write) begin
      case (funct3)
        F3_B, F3_H, F3_W: ok = 1'b1;
        default:          ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
        default:                        ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_lane_ctrl
// Combinational byte-lane logic for the data-memory responder. From funct3 and
// the low address bits it produces RAM byte enables, lane-replicated write data,
// and the extracted / sign- or zero-extended load data, plus the error flag.
//
// Configuration macro: DMEM_ALIGN_CHECK_EN
//   defined   : misaligned halfword/word accesses raise o_err (no write, data 0)
//   undefined : low address bits are forced (half uses addr[1], word ignores both)
//
// Ports:
//   i_write    in  1   1 = store, 0 = load
//   i_funct3   in  3   RV32I load/store funct3
//   i_addr_lo  in  2   byte offset within the word
//   i_wdata    in  32  right-aligned store data
//   i_word     in  32  current RAM word at the access index
//   o_be       out 4   byte enables for the RAM write (0 on error / load)
//   o_wdata    out 32  store data replicated onto every lane
//   o_rdata    out 32  extended load data (0 for stores and errors)
//   o_err      out 1   illegal funct3 or misaligned access
// -----------------------------------------------------------------------------
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic        i_write,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic        w_legal;
  logic        w_misalign;
  logic [1:0]  w_lane;
  logic [15:0] w_shifted;
  logic [31:0] w_ext;

  // Legality, alignment policy and the effective starting lane.
  always_comb begin
    w_legal    = f3_is_legal(i_write, i_funct3);
    w_misalign = 1'b0;
    w_lane     = i_addr_lo;
`ifdef DMEM_ALIGN_CHECK_EN
    case (i_funct3[1:0])
      2'b01:   w_misalign = i_addr_lo[0];
      2'b10:   w_misalign = (i_addr_lo != 2'b00);
      default: w_misalign = 1'b0;
    endcase
`else
    // Without checking, the offending low bits are simply dropped.
    case (i_funct3[1:0])
      2'b01:   w_lane = {i_addr_lo[1], 1'b0};
      2'b10:   w_lane = 2'b00;
      default: w_lane = i_addr_lo;
    endcase
`endif
    o_err = ~w_legal | w_misalign;
  end

  // Write side: data is replicated across lanes so only the enables pick the target.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    if (i_write && !o_err) begin
      case (i_funct3[1:0])
        2'b00: begin
          o_be    = 4'b0001 << w_lane;
          o_wdata = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          o_be    = 4'b0011 << w_lane;
          o_wdata = {2{i_wdata[15:0]}};
        end
        2'b10: begin
          o_be    = 4'b1111;
          o_wdata = i_wdata;
        end
        default: begin
          o_be    = 4'b0000;
          o_wdata = i_wdata;
        end
      endcase
    end else begin
      o_be    = 4'b0000;
      o_wdata = i_wdata;
    end
  end

  // Read side: bring the selected lane down to bit 0, then extend.
  always_comb begin
    w_shifted = 16'(i_word >> {w_lane, 3'b000});
    case (i_funct3)
      F3_B:    w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    w_ext = i_word;
      F3_BU:   w_ext = {24'd0, w_shifted[7:0]};
      F3_HU:   w_ext = {16'd0, w_shifted[15:0]};
      default: w_ext = 32'd0;
    endcase
    if (i_write || o_err) begin
      o_rdata = 32'd0;
    end else begin
      o_rdata = w_ext;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Target end of the core's data-memory port. Accepts one load/store at a time,
// waits LATENCY cycles, performs the byte-lane access on a word-organised RAM
// and returns the response over a valid/ready handshake.
//
// Configuration macro: DMEM_ALIGN_CHECK_EN (see dmem_lane_ctrl).
//
// Parameters:
//   ADDR_WIDTH  word-address bits; RAM is 2^ADDR_WIDTH x 32
//   LATENCY     wait-state cycles between accept and access (1..15)
//
// Ports:
//   clk         in  1   clock, rising edge
//   rst         in  1   asynchronous active-low reset
//   req_valid   in  1   request present
//   req_ready   out 1   responder can accept (only in IDLE, 0 during reset)
//   req_write   in  1   1 = store, 0 = load
//   req_funct3  in  3   RV32I load/store funct3
//   req_addr    in  32  byte address (wraps modulo RAM size)
//   req_wdata   in  32  right-aligned store data
//   rsp_valid   out 1   response present
//   rsp_ready   in  1   consumer takes the response
//   rsp_rdata   out 32  extended load data, 0 for stores and errors
//   rsp_err     out 1   illegal funct3 / misaligned access
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam int         LAT_EFF  = clamp_latency(LATENCY);
  localparam logic [3:0] CNT_LOAD = 4'(LAT_EFF - 1);

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_write;
  logic [2:0]              r_funct3;
  logic [ADDR_WIDTH+1:0]   r_addr;
  logic [31:0]             r_wdata;
  logic [31:0]             r_rdata;
  logic                    r_err;
  logic [31:0]             r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_access;
  logic [31:0]             w_word;
  logic [3:0]              w_be;
  logic [31:0]             w_lane_wdata;
  logic [31:0]             w_lane_rdata;
  logic                    w_lane_err;
  logic                    w_unused_addr;

  // Address bits above the RAM are deliberately dropped, giving modulo wrap.
  assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  assign w_idx    = r_addr[ADDR_WIDTH+1:2];
  assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_word   = r_mem[w_idx];

  // rst is folded in so the port reads 0 while reset is held, not just after it.
  assign req_ready = rst & (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  dmem_lane_ctrl u_lane_ctrl (
    .i_write   (r_write),
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_word    (w_word),
    .o_be      (w_be),
    .o_wdata   (w_lane_wdata),
    .o_rdata   (w_lane_rdata),
    .o_err     (w_lane_err)
  );

  // Request/response FSM with wait-state counter and registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_write  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[ADDR_WIDTH+1:0];
            r_wdata  <= req_wdata;
            r_cnt    <= CNT_LOAD;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rdata <= w_lane_rdata;
            r_err   <= w_lane_err;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          // The handshake edge only returns to IDLE; acceptance waits a cycle.
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // RAM byte-lane write on the access edge; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_access && r_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_lane_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed-vector bench for dmem_responder. The driver pushes each expected
// response into a queue; an independent monitor pops and compares whenever a
// response handshake occurs.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every completed response against the scoreboard head.
  always @(negedge clk) begin
    #1;
    if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rdata %h err %b with nothing expected", rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  // One complete transaction; called and returns at a negedge in IDLE.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int hold);
    int edges;
    exp_q.push_back({er, ee});
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    rsp_ready  = (hold == 0);
    edges = 0;
    while (!req_ready && edges < 20) begin
      @(posedge clk); @(negedge clk);
      edges++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: req_ready %b expected 1", req_ready);
      void'(exp_q.pop_back());
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); @(negedge clk);
    req_valid  = 1'b0;
    req_wdata  = 32'h5A5A5A5A;
    edges = 1;
    while (!rsp_valid && edges < 20) begin
      @(posedge clk); @(negedge clk);
      edges++;
    end
    chk("latency", 32'(edges), 32'(LAT + 1));
    for (int i = 0; i < hold; i++) begin
      #2;
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, er);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      // Competing request that must not be taken while a response is pending.
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0010;
      req_wdata  = 32'hBAD0BAD0;
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    if (hold > 0) begin
      #2;
      chk("no_accept_in_handshake", {31'd0, req_ready}, 32'd1);
      chk("idle_after_resp", {31'd0, rsp_valid}, 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Word store/load and byte lanes
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0);
    do_req(1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0,        1'b0, 0);
    do_req(1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 0);
    do_req(1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0, 0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 0);
    do_req(1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF80AD, 1'b0, 0);
    // Halfword lanes
    do_req(1'b1, 3'b010, 32'h20, 32'h13579BDF, 32'h0,        1'b0, 0);
    do_req(1'b1, 3'b001, 32'h22, 32'hFFFF8001, 32'h0,        1'b0, 0);
    do_req(1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFF8001, 1'b0, 0);
    do_req(1'b0, 3'b101, 32'h22, 32'h0,        32'h00008001, 1'b0, 0);
    do_req(1'b0, 3'b010, 32'h20, 32'h0,        32'h80019BDF, 1'b0, 0);
    do_req(1'b0, 3'b100, 32'h20, 32'h0,        32'h000000DF, 1'b0, 0);
    do_req(1'b0, 3'b000, 32'h21, 32'h0,        32'hFFFFFF9B, 1'b0, 0);
    do_req(1'b0, 3'b101, 32'h20, 32'h0,        32'h00009BDF, 1'b0, 0);
    // Back-pressure on the response
    do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 5);
    // Illegal funct3: error, zero data, no write
    do_req(1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 0);
    do_req(1'b0, 3'b110, 32'h10, 32'h0,        32'h0,        1'b1, 0);
    do_req(1'b0, 3'b111, 32'h10, 32'h0,        32'h0,        1'b1, 0);
    do_req(1'b1, 3'b011, 32'h10, 32'h00000000, 32'h0,        1'b1, 0);
    do_req(1'b1, 3'b100, 32'h10, 32'h00000000, 32'h0,        1'b1, 0);
    do_req(1'b1, 3'b111, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 0);
    // Address wrap: 0x1010 aliases word 4 of a 1K-word RAM
    do_req(1'b1, 3'b010, 32'h1010, 32'hCAFEF00D, 32'h0,      1'b0, 0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'hCAFEF00D, 1'b0, 0);
    // Misaligned accesses
    do_req(1'b1, 3'b010, 32'h10, 32'h12345678, 32'h0,        1'b0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    do_req(1'b0, 3'b010, 32'h11, 32'h0,        32'h0,        1'b1, 0);
    do_req(1'b1, 3'b010, 32'h12, 32'h0,        32'h0,        1'b1, 0);
    do_req(1'b0, 3'b001, 32'h13, 32'h0,        32'h0,        1'b1, 0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'h12345678, 1'b0, 0);
`else
    do_req(1'b0, 3'b010, 32'h11, 32'h0,        32'h12345678, 1'b0, 0);
    do_req(1'b0, 3'b101, 32'h13, 32'h0,        32'h00001234, 1'b0, 0);
    do_req(1'b1, 3'b010, 32'h12, 32'h0,        32'h0,        1'b0, 0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'h0,        1'b0, 0);
`endif
    // Reset in the middle of a store
    do_req(1'b1, 3'b010, 32'h30, 32'h11111111, 32'h0,        1'b0, 0);
    do_req(1'b0, 3'b010, 32'h30, 32'h0,        32'h11111111, 1'b0, 0);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h30;
    req_wdata  = 32'hA5A5A5A5;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("in_wait_req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    do_req(1'b0, 3'b010, 32'h30, 32'h0,        32'h11111111, 1'b0, 0);

    @(negedge clk); @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU's load/store port. It accepts one load or store request at a time over a valid/ready handshake and inserts a configurable number of wait states. It performs byte-lane writes for SB/SH/SW and sign- or zero-extends LB/LH/LBU/LHU data, then returns a response over a second valid/ready handshake. It sits between the core's data-access path and a word-organised on-chip RAM, and is the target end of the core's data-memory interface.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-address bits. The RAM holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: wait-state cycles between accept and memory access. Legal range 1..15.

Ports:
- `clk`  in  1  — the only clock; all state changes on its rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — responder can accept a request.
- `req_write`  in  1  — 1 = store, 0 = load.
- `req_funct3`  in  3  — RV32I load/store funct3.
- `req_addr`  in  32  — byte address.
- `req_wdata`  in  32  — store data, right-aligned.
- `rsp_valid`  out  1  — response present.
- `rsp_ready`  in  1  — consumer takes the response.
- `rsp_rdata`  out  32  — extended load data; 0 for stores and errors.
- `rsp_err`  out  1  — illegal funct3, or misaligned access (see Configuration).

## Operation
- State machine has three states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch write/funct3/addr/wdata, load the counter with LATENCY-1, and go to WAIT.
- **WAIT**
  - `req_ready` = 0. The counter decrements each cycle.
  - On the edge where counter == 0, perform the access, register `rsp_rdata`/`rsp_err`, and go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_rdata` and `rsp_err` stay stable until `rsp_ready` = 1, then go to IDLE.
  - No request is accepted in the handshake cycle.
- **Address handling**
  - Word index is addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses wrap modulo RAM size.
- **Stores**
  - SB (000): lane addr[1:0], byte wdata[7:0].
  - SH (001): lanes {addr[1],0} and {addr[1],1}, half wdata[15:0].
  - SW (010): all lanes.
  - Unselected lanes are unchanged.
- **Loads**
  - LB (000) / LH (001): sign-extend. LBU (100) / LHU (101): zero-extend.
  - LW (010): full word.
  - Lane selection is the same as for stores.
- **Illegal funct3**
  - Loads 011/110/111 and stores 011–111 set `rsp_err` = 1 and `rsp_rdata` = 0. No RAM write occurs.
- **RAM contents**
  - Not reset.

## Timing
- For a request accepted in cycle t, `rsp_valid` first rises in cycle t+LATENCY+1. With LATENCY=2, that is 3 cycles after acceptance.
- The store commits to RAM on the last WAIT edge.
- Minimum throughput is one request per LATENCY+2 cycles.
- **Reset values**
  - State IDLE, counter 0.
  - `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0.
  - `req_ready` is 0 while `rst` is low (`req_ready` = `rst` & IDLE).
- **Reset mid-operation**
  - An asserted reset takes effect immediately and abandons the request.
  - A store reset before its access edge never writes.
  - A pending response is dropped.
- While not in IDLE, `req_valid` is ignored and request inputs are don't-care.

## Configuration
- Macro: `DMEM_ALIGN_CHECK_EN`.
- **Defined**
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned.
  - Misaligned accesses return `rsp_err` = 1 and `rsp_rdata` = 0, with no write.
- **Undefined**
  - Low address bits are forced: halfword uses addr[1] only; word ignores addr[1:0].
  - `rsp_err` is raised only for illegal funct3.

## Structure
- Package `dmem_pkg` holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state typedef (IDLE/WAIT/RESP);
  - the LATENCY legal-range constants.
- Sub-module `dmem_lane_ctrl` (combinational) generates byte enables, lane-shifted write data, and load extraction/extension from funct3 and addr[1:0].
- The FSM, counter and RAM array live in the top level.

## Test plan
- SW 0x10 ← 0xDEADBEEF, then LW 0x10 → `rsp_rdata` 0xDEADBEEF, `rsp_err` 0, `rsp_valid` 3 cycles after accept (LATENCY=2).
- Then SB 0x13 ← 0x80 → LB 0x13 = 0xFFFFFF80, LBU 0x13 = 0x00000080, LW 0x10 = 0x80ADBEEF.
- SH 0x22 ← 0x8001 → LH 0x22 = 0xFFFF8001, LHU 0x22 = 0x00008001, LW 0x20 low half unchanged.
- Hold `rsp_ready` = 0 for 5 cycles during RESP → `rsp_valid`/`rsp_rdata` stable, `req_ready` 0, concurrent `req_valid` not accepted.
- LW 0x11 and SW 0x12 ← 0x0 over word 0x10 = 0x12345678:
  - with macro: err 1, rdata 0, word unchanged;
  - without: LW returns 0x12345678, store clears word.
- SW 0x30 ← 0x11111111 done; SW 0x30 ← 0xA5A5A5A5 with `rst` pulsed low in WAIT → outputs at reset values immediately; later LW 0x30 = 0x11111111.
